// File: rtl/multi_patch_reducer.sv
// N_SLOT independent patch accumulators sharing one pipelined float adder.
// Finished patches are handed out round-robin through a registered valid/ack stage.
module multi_patch_reducer #(
  parameter int N_ROW_SIZE   = 1,
  parameter int PATCH_SIZE   = 1,
  parameter int FP_SIZE      = 32,
  parameter int N_SLOT       = 4,
  parameter int FADD_LATENCY = 8,
  localparam int SW = (N_SLOT > 1) ? $clog2(N_SLOT) : 1
) (
  input  logic                  reset,
  input  logic                  dram_clk,
  input  logic                  init,
  input  logic [N_ROW_SIZE-1:0] start_row,
  output logic                  available,
  output logic [SW-1:0]         alloc_slot,
  input  logic [FP_SIZE-1:0]    partial_sum,
  input  logic [SW-1:0]         partial_sum_slot,
  input  logic                  partial_sum_valid,
  output logic                  partial_sum_rdy,
  output logic                  sum_rdy,
  output logic [FP_SIZE-1:0]    sum,
  output logic [N_ROW_SIZE-1:0] sum_row,
  output logic [SW-1:0]         sum_slot,
  input  logic                  sum_ack
);
  localparam int CW = $clog2(PATCH_SIZE + 1);
  localparam int EW = 8;
  localparam int MW = FP_SIZE - EW - 1;
  localparam logic signed [EW+1:0] ONE = (EW+2)'(1);

  typedef enum logic [1:0] {S_FREE, S_ACCUM, S_DONE} slot_state_t;

  slot_state_t             slot_state   [N_SLOT];
  logic [FP_SIZE-1:0]      slot_acc     [N_SLOT];
  logic [N_ROW_SIZE-1:0]   slot_row     [N_SLOT];
  logic                    slot_pending [N_SLOT];
  logic                    slot_held    [N_SLOT];

  logic                    op_nd_q;
  logic [FP_SIZE-1:0]      op_a_q, op_b_q;
  logic [SW-1:0]           op_slot_q;
  logic [FP_SIZE-1:0]      res_q   [FADD_LATENCY];
  logic                    rdy_q   [FADD_LATENCY];
  logic                    tag_v_q [FADD_LATENCY];
  logic [SW-1:0]           tag_s_q [FADD_LATENCY];

  logic                    sum_rdy_q;
  logic [FP_SIZE-1:0]      sum_q;
  logic [N_ROW_SIZE-1:0]   sum_row_q;
  logic [SW-1:0]           sum_slot_q, rr_q, rr_d, load_sel;
  logic                    load_found, load_fire, ack_fire, alloc_fire, accept;
  logic                    fadd_rdy, tag_valid, cmp_fire;
  logic [FP_SIZE-1:0]      acc_sel;

  // Round-to-nearest-even add; subnormals flush to zero, inputs assumed finite.
  function automatic logic [FP_SIZE-1:0] fp_add(input logic [FP_SIZE-1:0] a, input logic [FP_SIZE-1:0] b);
    logic [FP_SIZE-1:0]    x, y;
    logic [EW-1:0]         d;
    logic [MW+3:0]         mx, my;
    logic [MW+4:0]         s;
    logic [MW+1:0]         r;
    logic signed [EW+1:0]  e;
    logic                  sticky, up;
    if (a[FP_SIZE-2:0] >= b[FP_SIZE-2:0]) begin x = a; y = b; end
    else begin x = b; y = a; end
    if (y[FP_SIZE-2:MW] == '0) return (x[FP_SIZE-2:MW] == '0) ? '0 : x;
    mx = {1'b1, x[MW-1:0], 3'b000};
    my = {1'b1, y[MW-1:0], 3'b000};
    d = x[FP_SIZE-2:MW] - y[FP_SIZE-2:MW];
    sticky = 1'b0;
    for (int i = 0; i < MW + 4; i++)
      if (i < int'(d)) begin sticky = sticky | my[0]; my = my >> 1; end
    my[0] = my[0] | sticky;
    e = $signed({2'b00, x[FP_SIZE-2:MW]});
    if (x[FP_SIZE-1] == y[FP_SIZE-1]) begin
      s = {1'b0, mx} + {1'b0, my};
      if (s[MW+4]) begin s = {1'b0, s[MW+4:2], s[1] | s[0]}; e = e + ONE; end
    end else begin
      s = {1'b0, mx} - {1'b0, my};
      if (s == '0) return '0;
      for (int i = 0; i < MW + 3; i++)
        if (!s[MW+3]) begin s = s << 1; e = e - ONE; end
      if (e <= 0) return {x[FP_SIZE-1], {(FP_SIZE-1){1'b0}}};
    end
    up = s[2] & (s[1] | s[0] | s[3]);
    r  = {1'b0, s[MW+3:3]} + {{(MW+1){1'b0}}, up};
    if (r[MW+1]) begin r = r >> 1; e = e + ONE; end
    if (e >= 255) return {x[FP_SIZE-1], {EW{1'b1}}, {MW{1'b0}}};
    return {x[FP_SIZE-1], e[EW-1:0], r[MW-1:0]};
  endfunction

  always_comb begin
    available  = 1'b0;
    alloc_slot = '0;
    for (int i = N_SLOT - 1; i >= 0; i--)
      if (slot_state[i] == S_FREE) begin available = 1'b1; alloc_slot = SW'(i); end
  end

  always_comb begin
    partial_sum_rdy = 1'b0;
    acc_sel         = '0;
    for (int i = 0; i < N_SLOT; i++)
      if (partial_sum_slot == SW'(i)) begin
        partial_sum_rdy = (slot_state[i] == S_ACCUM) && !slot_pending[i];
        acc_sel         = slot_acc[i];
      end
  end

  assign accept     = partial_sum_valid && partial_sum_rdy;
  assign alloc_fire = init && available;
  assign ack_fire   = sum_ack && sum_rdy_q;
  assign fadd_rdy   = rdy_q[FADD_LATENCY-1];
  assign tag_valid  = tag_v_q[FADD_LATENCY-1];
  assign cmp_fire   = fadd_rdy && tag_valid;

  // Issue register feeding the adder, then a fixed-latency result/tag pipe.
  always_ff @(posedge dram_clk or posedge reset) begin
    if (reset) begin
      op_nd_q   <= 1'b0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_slot_q <= '0;
      for (int i = 0; i < FADD_LATENCY; i++) begin
        res_q[i] <= '0; rdy_q[i] <= 1'b0; tag_v_q[i] <= 1'b0; tag_s_q[i] <= '0;
      end
    end else begin
      op_nd_q    <= accept;
      op_a_q     <= acc_sel;
      op_b_q     <= partial_sum;
      op_slot_q  <= partial_sum_slot;
      res_q[0]   <= fp_add(op_a_q, op_b_q);
      rdy_q[0]   <= op_nd_q;
      tag_v_q[0] <= op_nd_q;
      tag_s_q[0] <= op_slot_q;
      for (int i = 1; i < FADD_LATENCY; i++) begin
        res_q[i] <= res_q[i-1]; rdy_q[i] <= rdy_q[i-1];
        tag_v_q[i] <= tag_v_q[i-1]; tag_s_q[i] <= tag_s_q[i-1];
      end
    end
  end

  for (genvar gi = 0; gi < N_SLOT; gi++) begin : g_slot
    slot_state_t           state_q;
    logic [FP_SIZE-1:0]    acc_q;
    logic [CW-1:0]         count_q;
    logic [N_ROW_SIZE-1:0] row_q;
    logic                  pending_q, held_q;

    always_ff @(posedge dram_clk or posedge reset) begin
      if (reset) begin
        state_q <= S_FREE; acc_q <= '0; count_q <= '0;
        row_q <= '0; pending_q <= 1'b0; held_q <= 1'b0;
      end else begin
        if (alloc_fire && alloc_slot == SW'(gi)) begin
          state_q <= S_ACCUM; acc_q <= '0; count_q <= '0; row_q <= start_row;
        end
        if (accept && partial_sum_slot == SW'(gi)) pending_q <= 1'b1;
        if (cmp_fire && tag_s_q[FADD_LATENCY-1] == SW'(gi)) begin
          acc_q     <= res_q[FADD_LATENCY-1];
          pending_q <= 1'b0;
          count_q   <= count_q + CW'(1);
          if (count_q == CW'(PATCH_SIZE - 1)) state_q <= S_DONE;
        end
        if (load_fire && load_sel == SW'(gi)) held_q <= 1'b1;
        if (ack_fire && sum_slot_q == SW'(gi)) begin state_q <= S_FREE; held_q <= 1'b0; end
      end
    end

    assign slot_state[gi]   = state_q;
    assign slot_acc[gi]     = acc_q;
    assign slot_row[gi]     = row_q;
    assign slot_pending[gi] = pending_q;
    assign slot_held[gi]    = held_q;
  end

  // First DONE slot not already presented, searching upward from rr_q with wrap.
  always_comb begin
    int j;
    j          = 0;
    load_found = 1'b0;
    load_sel   = '0;
    for (int k = 0; k < N_SLOT; k++) begin
      j = int'(rr_q) + k;
      if (j >= N_SLOT) j = j - N_SLOT;
      if (!load_found && slot_state[j] == S_DONE && !slot_held[j]) begin
        load_found = 1'b1; load_sel = SW'(j);
      end
    end
  end

  assign load_fire = load_found && (!sum_rdy_q || sum_ack);
  assign rr_d      = (load_sel == SW'(N_SLOT - 1)) ? '0 : load_sel + SW'(1);

  always_ff @(posedge dram_clk or posedge reset) begin
    if (reset) begin
      sum_rdy_q <= 1'b0; sum_q <= '0; sum_row_q <= '0; sum_slot_q <= '0; rr_q <= '0;
    end else if (load_fire) begin
      sum_rdy_q  <= 1'b1;
      sum_q      <= slot_acc[load_sel];
      sum_row_q  <= slot_row[load_sel];
      sum_slot_q <= load_sel;
      rr_q       <= rr_d;
    end else if (ack_fire) begin
      sum_rdy_q <= 1'b0;
    end
  end

  assign sum_rdy  = sum_rdy_q;
  assign sum      = sum_q;
  assign sum_row  = sum_row_q;
  assign sum_slot = sum_slot_q;
endmodule

// File: tb/tb_multi_patch_reducer.sv
// Bench for multi_patch_reducer: fixed patch table, directed corner sequences,
// then random traffic checked against an integer-sum scoreboard.
module tb_multi_patch_reducer;
  localparam int NR = 4, PS = 4, FP = 32, NS = 4, LAT = 8;

  logic          clk = 1'b0, rst = 1'b1, init = 1'b0;
  logic [NR-1:0] start_row = '0;
  logic          available;
  logic [1:0]    alloc_slot;
  logic [FP-1:0] partial_sum = '0;
  logic [1:0]    partial_sum_slot = '0;
  logic          partial_sum_valid = 1'b0, partial_sum_rdy;
  logic          sum_rdy, sum_ack = 1'b0;
  logic [FP-1:0] sum;
  logic [NR-1:0] sum_row;
  logic [1:0]    sum_slot;

  multi_patch_reducer #(.N_ROW_SIZE(NR), .PATCH_SIZE(PS), .FP_SIZE(FP), .N_SLOT(NS),
                        .FADD_LATENCY(LAT)) dut (
    .reset(rst), .dram_clk(clk), .init(init), .start_row(start_row),
    .available(available), .alloc_slot(alloc_slot), .partial_sum(partial_sum),
    .partial_sum_slot(partial_sum_slot), .partial_sum_valid(partial_sum_valid),
    .partial_sum_rdy(partial_sum_rdy), .sum_rdy(sum_rdy), .sum(sum), .sum_row(sum_row),
    .sum_slot(sum_slot), .sum_ack(sum_ack));

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  typedef struct packed {
    logic [3:0][31:0] a;
    logic [3:0]       row;
    logic [31:0]      exp_sum;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Exact for 0 <= n < 2^24.
  function automatic logic [31:0] int2fp(input int n);
    int m;
    logic [31:0] u;
    if (n == 0) return 32'h0;
    m = 0;
    for (int i = 0; i < 24; i++) if (((n >> i) & 1) != 0) m = i;
    u = 32'(n) << (23 - m);
    return {1'b0, 8'(127 + m), u[22:0]};
  endfunction

  task automatic do_alloc(input logic [3:0] row, input logic [1:0] exp_slot);
    init = 1'b1; start_row = row; #1;
    chk("alloc_available", 32'(available), 32'd1);
    chk("alloc_slot", 32'(alloc_slot), 32'(exp_slot));
    step(); init = 1'b0;
  endtask

  task automatic feed(input logic [1:0] slot, input logic [31:0] val);
    int t;
    t = 0;
    partial_sum_valid = 1'b1; partial_sum_slot = slot; partial_sum = val; #1;
    while (!partial_sum_rdy && t < 200) begin step(); #1; t++; end
    if (t >= 200) chk("feed_timeout", 32'(partial_sum_rdy), 32'd1);
    step(); partial_sum_valid = 1'b0;
  endtask

  task automatic wait_sum(input string nm);
    int t;
    t = 0;
    while (!sum_rdy && t < 300) begin step(); t++; end
    chk({nm, "_rdy"}, 32'(sum_rdy), 32'd1);
  endtask

  task automatic take(input logic [31:0] e_sum, input logic [3:0] e_row,
                      input logic [1:0] e_slot, input string nm);
    wait_sum(nm);
    chk({nm, "_sum"}, sum, e_sum);
    chk({nm, "_row"}, 32'(sum_row), 32'(e_row));
    chk({nm, "_slot"}, 32'(sum_slot), 32'(e_slot));
    sum_ack = 1'b1; step(); sum_ack = 1'b0;
  endtask

  // The adder's result strobe must always coincide with a valid tag.
  always @(negedge clk) begin
    if (!rst) begin
      n_vec++;
      if (dut.fadd_rdy !== dut.tag_valid) begin
        n_err++;
        $display("FAIL fadd_tag_sync: rdy %b tag_valid %b", dut.fadd_rdy, dut.tag_valid);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] e_sum [NS];
    logic [3:0]  e_row [NS];
    logic [31:0] hold_sum;
    logic [1:0]  hold_slot;
    logic        seen [NS];
    logic        any_rdy;
    int          m_st [NS], m_cnt [NS], m_sum [NS];
    logic [3:0]  m_row [NS];
    int          t, v, lo;
    logic        any_free;
    logic [1:0]  s;

    tbl[0] = '{a: {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000}, row: 4'd5,  exp_sum: 32'h41200000};
    tbl[1] = '{a: {32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000}, row: 4'd7,  exp_sum: 32'h41000000};
    tbl[2] = '{a: {32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000}, row: 4'd8,  exp_sum: 32'h40800000};
    tbl[3] = '{a: {32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000}, row: 4'd0,  exp_sum: 32'h00000000};
    tbl[4] = '{a: {32'h43C80000, 32'h43960000, 32'h43480000, 32'h42C80000}, row: 4'd15, exp_sum: 32'h447A0000};
    tbl[5] = '{a: {32'h3F000000, 32'hBF800000, 32'hC0000000, 32'h40400000}, row: 4'd9,  exp_sum: 32'h3F000000};
    tbl[6] = '{a: {32'h00000000, 32'hC0900000, 32'h40A00000, 32'h00000000}, row: 4'd3,  exp_sum: 32'h3F000000};

    // Reset values
    rst = 1'b1; step(); step();
    chk("reset_available", 32'(available), 32'd1);
    chk("reset_alloc_slot", 32'(alloc_slot), 32'd0);
    chk("reset_sum_rdy", 32'(sum_rdy), 32'd0);
    chk("reset_sum", sum, 32'd0);
    chk("reset_sum_row", 32'(sum_row), 32'd0);
    chk("reset_sum_slot", 32'(sum_slot), 32'd0);
    chk("reset_ps_rdy", 32'(partial_sum_rdy), 32'd0);
    rst = 1'b0; step();

    // Table of single patches on slot 0
    for (int i = 0; i < 7; i++) begin
      do_alloc(tbl[i].row, 2'd0);
      for (int k = 0; k < 4; k++) feed(2'd0, tbl[i].a[k]);
      take(tbl[i].exp_sum, tbl[i].row, 2'd0, $sformatf("tbl%0d", i));
      chk("tbl_freed", 32'(available), 32'd1);
      chk("tbl_freed_slot", 32'(alloc_slot), 32'd0);
      chk("tbl_sum_rdy_clear", 32'(sum_rdy), 32'd0);
    end

    // Back-pressure: second addend held valid while the first is in flight
    do_alloc(4'd3, 2'd0);
    feed(2'd0, 32'h3F800000);
    partial_sum_valid = 1'b1; partial_sum_slot = 2'd0; partial_sum = 32'h40000000; #1;
    chk("bp_rdy_low", 32'(partial_sum_rdy), 32'd0);
    t = 0;
    while (!partial_sum_rdy && t < 200) begin step(); #1; t++; end
    chk("bp_wait_ge_latency", 32'(t >= LAT), 32'd1);
    step(); partial_sum_valid = 1'b0;
    feed(2'd0, 32'h40400000);
    feed(2'd0, 32'h40800000);
    take(32'h41200000, 4'd3, 2'd0, "bp");

    // Full: all slots allocated, extra init ignored, init+ack collision
    do_alloc(4'd7, 2'd0);
    do_alloc(4'd8, 2'd1);
    do_alloc(4'd9, 2'd2);
    do_alloc(4'd10, 2'd3);
    chk("full_available", 32'(available), 32'd0);
    init = 1'b1; start_row = 4'd15; step(); init = 1'b0;
    chk("full_extra_init", 32'(available), 32'd0);
    for (int k = 0; k < 4; k++) feed(2'd2, 32'h3F800000);
    wait_sum("full");
    chk("full_sum", sum, 32'h40800000);
    chk("full_row", 32'(sum_row), 32'd9);
    chk("full_slot", 32'(sum_slot), 32'd2);
    init = 1'b1; start_row = 4'd12; sum_ack = 1'b1; #1;
    chk("collide_available_pre", 32'(available), 32'd0);
    step(); init = 1'b0; sum_ack = 1'b0;
    chk("collide_available_post", 32'(available), 32'd1);
    chk("collide_alloc_slot", 32'(alloc_slot), 32'd2);
    chk("collide_sum_rdy", 32'(sum_rdy), 32'd0);
    do_alloc(4'd13, 2'd2);
    chk("refill_available", 32'(available), 32'd0);

    // Interleaved patches, then output stall and back-to-back drain
    e_sum = '{32'h41000000, 32'h40800000, 32'h41400000, 32'h41200000};
    e_row = '{4'd7, 4'd8, 4'd13, 4'd10};
    for (int k = 0; k < 4; k++) begin
      feed(2'd0, 32'h40000000);
      feed(2'd1, 32'h3F800000);
      feed(2'd3, int2fp(k + 1));
      feed(2'd2, 32'h40400000);
    end
    for (int k = 0; k < LAT + 12; k++) step();
    chk("stall_rdy", 32'(sum_rdy), 32'd1);
    hold_sum = sum; hold_slot = sum_slot;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("stall_sum_stable", sum, hold_sum);
      chk("stall_slot_stable", 32'(sum_slot), 32'(hold_slot));
    end
    for (int k = 0; k < NS; k++) seen[k] = 1'b0;
    sum_ack = 1'b1;
    for (int k = 0; k < NS; k++) begin
      s = sum_slot;
      chk("burst_rdy", 32'(sum_rdy), 32'd1);
      chk("burst_sum", sum, e_sum[s]);
      chk("burst_row", 32'(sum_row), 32'(e_row[s]));
      chk("burst_distinct", 32'(seen[s]), 32'd0);
      seen[s] = 1'b1;
      step();
    end
    sum_ack = 1'b0;
    chk("burst_empty", 32'(sum_rdy), 32'd0);
    chk("burst_available", 32'(available), 32'd1);

    // Reset with two addends in flight
    do_alloc(4'd1, 2'd0);
    do_alloc(4'd2, 2'd1);
    feed(2'd0, 32'h40000000);
    feed(2'd1, 32'h40000000);
    rst = 1'b1; #1;
    chk("midrst_sum_rdy", 32'(sum_rdy), 32'd0);
    chk("midrst_available", 32'(available), 32'd1);
    chk("midrst_alloc_slot", 32'(alloc_slot), 32'd0);
    chk("midrst_sum", sum, 32'd0);
    step(); step(); rst = 1'b0;
    any_rdy = 1'b0;
    for (int k = 0; k < 20; k++) begin step(); any_rdy = any_rdy | sum_rdy; end
    chk("postrst_no_sum", 32'(any_rdy), 32'd0);
    do_alloc(tbl[4].row, 2'd0);
    for (int k = 0; k < 4; k++) feed(2'd0, tbl[4].a[k]);
    take(tbl[4].exp_sum, tbl[4].row, 2'd0, "postrst");

    // Random traffic against an integer-sum scoreboard
    for (int i = 0; i < NS; i++) begin m_st[i] = 0; m_cnt[i] = 0; m_sum[i] = 0; m_row[i] = '0; end
    for (int c = 0; c < 2500; c++) begin
      init              = ($urandom_range(0, 99) < 30);
      start_row         = 4'($urandom);
      partial_sum_valid = ($urandom_range(0, 99) < 70);
      partial_sum_slot  = 2'($urandom);
      v                 = int'($urandom_range(0, 255));
      partial_sum       = int2fp(v);
      sum_ack           = ($urandom_range(0, 99) < 40);
      #1;
      any_free = 1'b0; lo = 0;
      for (int i = NS - 1; i >= 0; i--) if (m_st[i] == 0) begin any_free = 1'b1; lo = i; end
      chk("rnd_available", 32'(available), 32'(any_free));
      if (any_free) chk("rnd_alloc_slot", 32'(alloc_slot), 32'(lo));
      s = partial_sum_slot;
      chk("rnd_rdy_legal", 32'(partial_sum_rdy && !(m_st[s] == 1 && m_cnt[s] < PS)), 32'd0);
      if (init && any_free) begin
        m_st[lo] = 1; m_cnt[lo] = 0; m_sum[lo] = 0; m_row[lo] = start_row;
      end
      if (partial_sum_valid && partial_sum_rdy) begin
        m_sum[s] = m_sum[s] + v; m_cnt[s] = m_cnt[s] + 1;
      end
      if (sum_ack && sum_rdy) begin
        s = sum_slot;
        chk("rnd_out_complete", 32'(m_st[s] == 1 && m_cnt[s] == PS), 32'd1);
        chk("rnd_sum", sum, int2fp(m_sum[s]));
        chk("rnd_row", 32'(sum_row), 32'(m_row[s]));
        m_st[s] = 0;
      end
      step();
    end
    init = 1'b0; partial_sum_valid = 1'b0; sum_ack = 1'b1;
    for (int c = 0; c < 300; c++) begin
      #1;
      if (sum_rdy) begin
        s = sum_slot;
        chk("drain_complete", 32'(m_st[s] == 1 && m_cnt[s] == PS), 32'd1);
        chk("drain_sum", sum, int2fp(m_sum[s]));
        chk("drain_row", 32'(sum_row), 32'(m_row[s]));
        m_st[s] = 0;
      end
      step();
    end
    sum_ack = 1'b0;
    for (int i = 0; i < NS; i++)
      chk("drain_missing", 32'(m_st[i] == 1 && m_cnt[i] == PS), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
